uart_rx_frame_parser: RTL and testbench
=======================================

UART_RX_FRAME_PARSER -- requirements
Module: uart_rx_frame_parser

Interface
REQ-001 SHALL have parameter P_UART_DATA_WIDTH, default 8, byte width from the receiver.
REQ-002 SHALL have parameter P_HEAD0, default 8'h55, first header byte.
REQ-003 SHALL have parameter P_HEAD1, default 8'hAA, second header byte.
REQ-004 SHALL have parameter P_MAX_LEN, default 16, max payload bytes (1..255).
REQ-005 SHALL have parameter P_TIMEOUT, default 50_000, max idle clocks between bytes inside a frame.
REQ-006 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_uart_rx_data, input, P_UART_DATA_WIDTH, received byte from the UART receiver.
REQ-009 SHALL have port i_uart_rx_valid, input, 1, one-cycle strobe qualifying i_uart_rx_data; no backpressure.
REQ-010 SHALL have port o_frame_data, output, P_UART_DATA_WIDTH, payload byte.
REQ-011 SHALL have port o_frame_valid, output, 1, payload byte valid.
REQ-012 SHALL have port o_frame_last, output, 1, marks final payload byte.
REQ-013 SHALL have port i_frame_ready, input, 1, consumer accepts byte when high with o_frame_valid.
REQ-014 SHALL have port o_frame_len, output, 8, LEN of frame being streamed, stable during OUT.
REQ-015 SHALL have ports o_err (1, one-cycle pulse) and o_err_code (2; 1=bad LEN, 2=checksum mismatch, 3=timeout), code held until next error.
REQ-016 SHALL have port o_drop, output, 1, one-cycle pulse per input byte discarded during OUT.

Function
REQ-017 Frame format SHALL be HEAD0, HEAD1, LEN, LEN payload bytes, CSUM; CSUM = (LEN + sum of payload) mod 256.
REQ-018 FSM states SHALL be IDLE, HEAD1, LEN, DATA, CSUM, OUT; transitions only on i_uart_rx_valid except timeout and OUT handshakes.
REQ-019 IDLE: byte==P_HEAD0 -> HEAD1; any other byte ignored silently.
REQ-020 HEAD1: byte==P_HEAD1 -> LEN; byte==P_HEAD0 -> stay HEAD1; else -> IDLE, no error.
REQ-021 LEN: byte 0 or >P_MAX_LEN -> IDLE with o_err, code 1; else latch LEN, clear checksum to LEN -> DATA.
REQ-022 DATA: write byte to buffer at write index, add to checksum with 8-bit wrap; after LEN-th byte -> CSUM.
REQ-023 CSUM: match -> OUT with o_frame_valid high the next cycle; mismatch -> IDLE with o_err, code 2, buffer discarded.
REQ-024 Timeout counter SHALL reset on every accepted byte and in IDLE/OUT; reaching P_TIMEOUT in HEAD1..CSUM -> IDLE with o_err, code 3.
REQ-025 OUT: present buffer[read index]; advance on o_frame_valid && i_frame_ready; o_frame_last high with index LEN-1; transfer of last byte -> IDLE.
REQ-026 o_frame_data/o_frame_last SHALL stay stable while o_frame_valid && !i_frame_ready.
REQ-027 Input bytes arriving in OUT SHALL be discarded with o_drop; they SHALL NOT start a new frame.
REQ-028 Timeout and byte arrival in the same cycle: byte wins, counter resets.
REQ-029 o_err and o_drop SHALL never assert for the same byte.

Reset
REQ-030 On i_rst_n low, asynchronously: state IDLE, indices/checksum/timeout cleared, o_frame_valid, o_frame_last, o_err, o_drop = 0, o_frame_data, o_frame_len, o_err_code = 0.
REQ-031 Reset mid-frame or mid-OUT SHALL abandon the frame without any error pulse after release.
REQ-032 Buffer contents SHALL need no reset.

Structure
REQ-033 State encodings and o_err_code values SHALL live in the shared UART definitions header.
REQ-034 Payload storage SHALL be one sub-module uart_frame_buf: P_MAX_LEN x P_UART_DATA_WIDTH, one write port, one asynchronous read port.

Verification
REQ-035 Bytes 55 AA 03 11 22 33 69, ready=1 -> 11,22,33 on consecutive cycles, last on 33, len=3, no err.
REQ-036 55 AA 02 01 02 00 -> o_err, code 2, no o_frame_valid.
REQ-037 55 AA 00, then 55 AA 11 (P_MAX_LEN=16) -> two o_err pulses, code 1.
REQ-038 55 AA 02 01, then idle P_TIMEOUT clocks -> o_err code 3; following valid frame parsed correctly.
REQ-039 Valid 2-byte frame with ready held low 20 cycles, 3 bytes input meanwhile -> data stable, 3 o_drop pulses, both bytes delivered after ready.
REQ-040 55 55 AA 01 7E 7F -> byte 7E delivered (HEAD0 repeat tolerated); reset asserted mid-DATA -> all outputs 0, no err.

Source files
------------

// File: rtl/uart_rx_frame_parser_pkg.sv
// rtl/uart_rx_frame_parser_pkg.sv - shared UART definitions: parser states and error codes
package uart_rx_frame_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD1 = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_OUT   = 3'd5
    } frame_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload store, one write port and one asynchronous read port
module uart_frame_buf #(
    parameter int P_DEPTH = 16,
    parameter int P_WIDTH = 8,
    parameter int P_AW    = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [P_AW-1:0]    i_waddr,
    input  logic [P_WIDTH-1:0] i_wdata,
    input  logic [P_AW-1:0]    i_raddr,
    output logic [P_WIDTH-1:0] o_rdata
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - parses HEAD0 HEAD1 LEN payload CSUM frames from a UART byte stream
module uart_rx_frame_parser
    import uart_rx_frame_parser_pkg::*;
#(
    parameter int                           P_UART_DATA_WIDTH = 8,
    parameter logic [P_UART_DATA_WIDTH-1:0] P_HEAD0           = 8'h55,
    parameter logic [P_UART_DATA_WIDTH-1:0] P_HEAD1           = 8'hAA,
    parameter int                           P_MAX_LEN         = 16,
    parameter int                           P_TIMEOUT         = 50_000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [P_UART_DATA_WIDTH-1:0] i_uart_rx_data,
    input  logic                         i_uart_rx_valid,
    output logic [P_UART_DATA_WIDTH-1:0] o_frame_data,
    output logic                         o_frame_valid,
    output logic                         o_frame_last,
    input  logic                         i_frame_ready,
    output logic [7:0]                   o_frame_len,
    output logic                         o_err,
    output logic [1:0]                   o_err_code,
    output logic                         o_drop
);

    localparam int         AW       = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
    localparam int         TW       = $clog2(P_TIMEOUT + 1);
    localparam logic [7:0] MAX_LEN8 = 8'(P_MAX_LEN);
    localparam logic [TW-1:0] TMAX  = TW'(P_TIMEOUT - 1);

    frame_state_t state_q, state_d;

    logic [7:0]                   len_q;
    logic [7:0]                   wr_idx;
    logic [7:0]                   rd_idx;
    logic [7:0]                   csum_q;
    logic [TW-1:0]                tmo_q;
    logic [7:0]                   byte8;
    logic                         in_frame;
    logic                         tmo_hit;
    logic                         buf_we;
    logic                         err_d;
    logic [1:0]                   err_code_d;
    logic                         drop_d;
    logic [P_UART_DATA_WIDTH-1:0] rd_data;

    assign byte8    = 8'(i_uart_rx_data);
    assign in_frame = (state_q == ST_HEAD1) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA)  || (state_q == ST_CSUM);
    // An arriving byte always beats an expiring timer.
    assign tmo_hit  = in_frame && !i_uart_rx_valid && (tmo_q == TMAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        err_code_d = o_err_code;
        drop_d     = 1'b0;
        buf_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_uart_rx_valid && i_uart_rx_data == P_HEAD0) state_d = ST_HEAD1;
            end
            ST_HEAD1: begin
                if (i_uart_rx_valid) begin
                    if (i_uart_rx_data == P_HEAD1)      state_d = ST_LEN;
                    else if (i_uart_rx_data != P_HEAD0) state_d = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (i_uart_rx_valid) begin
                    if (byte8 == 8'd0 || byte8 > MAX_LEN8) begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_LEN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (i_uart_rx_valid) begin
                    buf_we = 1'b1;
                    if (wr_idx == len_q - 8'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (i_uart_rx_valid) begin
                    if (byte8 == csum_q) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            ST_OUT: begin
                drop_d = i_uart_rx_valid;
                if (i_frame_ready && rd_idx == len_q - 8'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q      <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
            o_drop     <= 1'b0;
        end else begin
            o_err      <= err_d;
            o_err_code <= err_code_d;
            o_drop     <= drop_d;
            if (in_frame && !i_uart_rx_valid) tmo_q <= tmo_q + 1'b1;
            else                              tmo_q <= '0;
            if (state_q == ST_LEN && state_d == ST_DATA) begin
                len_q  <= byte8;
                csum_q <= byte8;
                wr_idx <= '0;
            end
            if (buf_we) begin
                wr_idx <= wr_idx + 8'd1;
                csum_q <= csum_q + byte8;
            end
            if (state_q == ST_CSUM && state_d == ST_OUT) rd_idx <= '0;
            if (state_q == ST_OUT && i_frame_ready)     rd_idx <= rd_idx + 8'd1;
        end
    end

    uart_frame_buf #(
        .P_DEPTH (P_MAX_LEN),
        .P_WIDTH (P_UART_DATA_WIDTH),
        .P_AW    (AW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (buf_we),
        .i_waddr (wr_idx[AW-1:0]),
        .i_wdata (i_uart_rx_data),
        .i_raddr (rd_idx[AW-1:0]),
        .o_rdata (rd_data)
    );

    assign o_frame_valid = (state_q == ST_OUT);
    assign o_frame_data  = o_frame_valid ? rd_data : '0;
    assign o_frame_last  = o_frame_valid && (rd_idx == len_q - 8'd1);
    assign o_frame_len   = len_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - directed self-checking bench for uart_rx_frame_parser
module tb_uart_rx_frame_parser;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       frame_last;
    logic       frame_ready = 1'b1;
    logic [7:0] frame_len;
    logic       err;
    logic [1:0] err_code;
    logic       drop;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int drop_cnt = 0;
    int stable_bad;
    logic [7:0] got_data[$];
    logic       got_last[$];
    int         got_cyc[$];

    uart_rx_frame_parser #(
        .P_UART_DATA_WIDTH (8),
        .P_HEAD0           (8'h55),
        .P_HEAD1           (8'hAA),
        .P_MAX_LEN         (16),
        .P_TIMEOUT         (TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_uart_rx_data  (rx_data),
        .i_uart_rx_valid (rx_valid),
        .o_frame_data    (frame_data),
        .o_frame_valid   (frame_valid),
        .o_frame_last    (frame_last),
        .i_frame_ready   (frame_ready),
        .o_frame_len     (frame_len),
        .o_err           (err),
        .o_err_code      (err_code),
        .o_drop          (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (err)  err_cnt  = err_cnt + 1;
        if (drop) drop_cnt = drop_cnt + 1;
        if (frame_valid && frame_ready) begin
            got_data.push_back(frame_data);
            got_last.push_back(frame_last);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        err_cnt  = 0;
        drop_cnt = 0;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        idle(3);
        check("rst_valid", frame_valid, 0);
        check("rst_last",  frame_last, 0);
        check("rst_err",   err, 0);
        check("rst_drop",  drop, 0);
        check("rst_data",  frame_data, 0);
        check("rst_len",   frame_len, 0);
        check("rst_code",  err_code, 0);
        rst_n = 1'b1;
        idle(2);

        // good 3-byte frame, ready high
        clear_mon();
        frame_ready = 1'b1;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        check("f3_valid_next", frame_valid, 1);
        check("f3_len", frame_len, 3);
        idle(6);
        check("f3_count", got_data.size(), 3);
        if (got_data.size() == 3) begin
            check("f3_d0", got_data[0], 8'h11);
            check("f3_d1", got_data[1], 8'h22);
            check("f3_d2", got_data[2], 8'h33);
            check("f3_l0", got_last[0], 0);
            check("f3_l1", got_last[1], 0);
            check("f3_l2", got_last[2], 1);
            check("f3_consec1", got_cyc[1] - got_cyc[0], 1);
            check("f3_consec2", got_cyc[2] - got_cyc[1], 1);
        end
        check("f3_err", err_cnt, 0);

        // checksum mismatch
        clear_mon();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        idle(4);
        check("cs_err_cnt", err_cnt, 1);
        check("cs_code", err_code, 2);
        check("cs_no_valid", got_data.size(), 0);

        // bad LEN: zero, then above max
        clear_mon();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
        idle(4);
        check("len_err_cnt", err_cnt, 2);
        check("len_code", err_code, 1);
        check("len_no_valid", got_data.size(), 0);

        // timeout mid-DATA, then a good frame
        clear_mon();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
        idle(TMO - 10);
        check("tmo_not_early", err_cnt, 0);
        for (int i = 0; i < 25 && err_cnt == 0; i++) idle(1);
        check("tmo_err_cnt", err_cnt, 1);
        check("tmo_code", err_code, 3);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
        send_byte(8'hA0); send_byte(8'hB0); send_byte(8'h52);
        idle(5);
        check("tmo_f_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("tmo_f_d0", got_data[0], 8'hA0);
            check("tmo_f_d1", got_data[1], 8'hB0);
            check("tmo_f_l1", got_last[1], 1);
        end
        check("tmo_f_err", err_cnt, 1);

        // backpressure with bytes arriving during OUT
        clear_mon();
        frame_ready = 1'b0;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'h85);
        stable_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            rx_valid = (i == 3) || (i == 8) || (i == 13);
            rx_data  = (i == 3) ? 8'h55 : (i == 8) ? 8'hAA : 8'h01;
            if (!(frame_valid && frame_data == 8'hC1 && !frame_last)) stable_bad++;
        end
        rx_valid = 1'b0;
        idle(2);
        check("bp_stable", stable_bad, 0);
        check("bp_drops", drop_cnt, 3);
        check("bp_err", err_cnt, 0);
        frame_ready = 1'b1;
        idle(6);
        check("bp_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("bp_d0", got_data[0], 8'hC1);
            check("bp_d1", got_data[1], 8'hC2);
            check("bp_l0", got_last[0], 0);
            check("bp_l1", got_last[1], 1);
        end

        // repeated HEAD0 tolerated
        clear_mon();
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
        send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        idle(4);
        check("hh_count", got_data.size(), 1);
        if (got_data.size() == 1) begin
            check("hh_d0", got_data[0], 8'h7E);
            check("hh_l0", got_last[0], 1);
        end

        // reset mid-DATA
        clear_mon();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
        send_byte(8'h10); send_byte(8'h20);
        rst_n = 1'b0;
        #1;
        check("mr_valid", frame_valid, 0);
        check("mr_err",   err, 0);
        check("mr_drop",  drop, 0);
        check("mr_len",   frame_len, 0);
        check("mr_code",  err_code, 0);
        idle(2);
        rst_n = 1'b1;
        idle(TMO + 10);
        check("mr_no_err", err_cnt, 0);
        check("mr_no_out", got_data.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
